// File: rtl/multiport_regfile.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : multiport_regfile
//  Description : Parametrised multi-port register file with N_RD registered
//                read ports and N_WR write ports. Features:
//                  - post-reset initialisation sequencer; `ready` rises once
//                    every entry has been written
//                  - same-cycle write-to-read bypass (write-first)
//                  - highest write-port index wins on address conflicts,
//                    reported on a one-cycle registered wr_conflict pulse
//                  - optional hardwired zero register at entry 0
//  Ports       : clk, rstn (sync, active-low)
//                ready                      - initialisation complete
//                rd_en/rd_addr              - per-port read request/address
//                rd_data/rd_valid           - registered read result (lat 1)
//                wr_en/wr_addr/wr_data      - per-port write request
//                wr_conflict                - >=2 live writes to one address
//  Revision    : 1.0 - initial release
// ============================================================================
module multiport_regfile #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 6,
    parameter int N_RD      = 8,
    parameter int N_WR      = 2,
    parameter int ZERO_REG  = 1,
    parameter int INIT_MODE = 1
) (
    input  logic                     clk,
    input  logic                     rstn,
    output logic                     ready,
    input  logic [N_RD-1:0]          rd_en,
    input  logic [N_RD*ADDR_W-1:0]   rd_addr,
    output logic [N_RD*DATA_W-1:0]   rd_data,
    output logic [N_RD-1:0]          rd_valid,
    input  logic [N_WR-1:0]          wr_en,
    input  logic [N_WR*ADDR_W-1:0]   wr_addr,
    input  logic [N_WR*DATA_W-1:0]   wr_data,
    output logic                     wr_conflict
);

    localparam int              c_DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] c_LAST_IDX = (ADDR_W+1)'(c_DEPTH - 1);
    localparam logic [ADDR_W:0] c_IDX_ONE  = (ADDR_W+1)'(1);
    localparam bit              c_ZERO_EN  = (ZERO_REG != 0);

    logic [DATA_W-1:0]   r_mem [c_DEPTH];

    // r_ready doubles as the INIT/RUN state bit.
    logic                r_ready;
    logic [ADDR_W:0]     r_init_idx;      // one extra bit so the terminal compare never wraps
    logic [N_RD*DATA_W-1:0] r_rd_data;
    logic [N_RD-1:0]     r_rd_valid;
    logic                r_wr_conflict;

    logic [ADDR_W-1:0]   w_init_addr;
    logic [DATA_W-1:0]   w_init_val;
    logic [ADDR_W-1:0]   w_wr_addr [N_WR];
    logic [DATA_W-1:0]   w_wr_data [N_WR];
    logic [N_WR-1:0]     w_wr_eff;        // write actually lands (RUN, enabled, not zero reg)
    logic [ADDR_W-1:0]   w_rd_addr [N_RD];
    logic [DATA_W-1:0]   w_rd_val  [N_RD];
    logic                w_conflict;

    assign w_init_addr = r_init_idx[ADDR_W-1:0];

    // ------------------------------------------------------------------
    // Initialisation value: entry index (zero-extended or truncated) or 0
    // ------------------------------------------------------------------
    if (INIT_MODE == 0) begin : g_init_clear
        assign w_init_val = '0;
    end else if (DATA_W > ADDR_W) begin : g_init_zext
        assign w_init_val = {{(DATA_W-ADDR_W){1'b0}}, w_init_addr};
    end else begin : g_init_trunc
        assign w_init_val = w_init_addr[DATA_W-1:0];
    end

    // ------------------------------------------------------------------
    // Write port unpacking and qualification
    // ------------------------------------------------------------------
    for (genvar g = 0; g < N_WR; g++) begin : g_wr_port
        assign w_wr_addr[g] = wr_addr[g*ADDR_W +: ADDR_W];
        assign w_wr_data[g] = wr_data[g*DATA_W +: DATA_W];
        // Writes to the zero register vanish entirely, so they neither
        // bypass nor count toward a conflict.
        assign w_wr_eff[g]  = r_ready && wr_en[g] &&
                              !(c_ZERO_EN && (w_wr_addr[g] == '0));
    end

    // Any pair of live writes on the same address.
    always_comb begin
        w_conflict = 1'b0;
        for (int j = 0; j < N_WR; j++) begin
            for (int k = j + 1; k < N_WR; k++) begin
                if (w_wr_eff[j] && w_wr_eff[k] && (w_wr_addr[j] == w_wr_addr[k])) begin
                    w_conflict = 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read port next-value: storage, overridden by same-cycle writes in
    // ascending port order so the highest index wins, then zero register.
    // ------------------------------------------------------------------
    for (genvar g = 0; g < N_RD; g++) begin : g_rd_port
        assign w_rd_addr[g] = rd_addr[g*ADDR_W +: ADDR_W];

        always_comb begin
            w_rd_val[g] = r_mem[w_rd_addr[g]];
            for (int j = 0; j < N_WR; j++) begin
                if (w_wr_eff[j] && (w_wr_addr[j] == w_rd_addr[g])) begin
                    w_rd_val[g] = w_wr_data[j];
                end
            end
            if (c_ZERO_EN && (w_rd_addr[g] == '0)) begin
                w_rd_val[g] = '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Storage: not reset; filled by the init sequencer after reset.
    // Later loop iterations override earlier ones, giving the highest
    // write port priority on a shared address.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rstn) begin
            if (!r_ready) begin
                r_mem[w_init_addr] <= w_init_val;
            end
            for (int j = 0; j < N_WR; j++) begin
                if (w_wr_eff[j]) begin
                    r_mem[w_wr_addr[j]] <= w_wr_data[j];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Control, init sequencer and registered read outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_ready       <= 1'b0;
            r_init_idx    <= '0;
            r_rd_data     <= '0;
            r_rd_valid    <= '0;
            r_wr_conflict <= 1'b0;
        end else begin
            r_wr_conflict <= w_conflict;
            if (!r_ready) begin
                r_init_idx <= r_init_idx + c_IDX_ONE;
                if (r_init_idx == c_LAST_IDX) begin
                    r_ready <= 1'b1;
                end
            end
            for (int i = 0; i < N_RD; i++) begin
                r_rd_valid[i] <= r_ready && rd_en[i];
                if (r_ready && rd_en[i]) begin
                    r_rd_data[i*DATA_W +: DATA_W] <= w_rd_val[i];
                end
            end
        end
    end

    assign ready       = r_ready;
    assign rd_data     = r_rd_data;
    assign rd_valid    = r_rd_valid;
    assign wr_conflict = r_wr_conflict;

endmodule
`default_nettype wire

// File: tb/tb_multiport_regfile.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_multiport_regfile
//  Description : Directed self-checking bench for multiport_regfile. Read
//                expectations are queued when a read is issued and compared
//                one edge later. A second instance with ZERO_REG=0 shares the
//                stimulus to contrast zero-register behaviour.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multiport_regfile;

    localparam int DW = 32;
    localparam int AW = 6;
    localparam int NR = 8;
    localparam int NW = 2;

    logic              clk = 1'b0;
    logic              rstn;
    logic [NR-1:0]     rd_en;
    logic [NR*AW-1:0]  rd_addr;
    logic [NW-1:0]     wr_en;
    logic [NW*AW-1:0]  wr_addr;
    logic [NW*DW-1:0]  wr_data;

    logic              ready,       nz_ready;
    logic [NR*DW-1:0]  rd_data,     nz_rd_data;
    logic [NR-1:0]     rd_valid,    nz_rd_valid;
    logic              wr_conflict, nz_wr_conflict;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int          port;
        logic [31:0] data;
        string       tag;
    } rd_exp_t;

    rd_exp_t sb[$];

    multiport_regfile #(
        .DATA_W(DW), .ADDR_W(AW), .N_RD(NR), .N_WR(NW), .ZERO_REG(1), .INIT_MODE(1)
    ) dut (
        .clk(clk), .rstn(rstn), .ready(ready),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_conflict(wr_conflict)
    );

    multiport_regfile #(
        .DATA_W(DW), .ADDR_W(AW), .N_RD(NR), .N_WR(NW), .ZERO_REG(0), .INIT_MODE(1)
    ) dut_nz (
        .clk(clk), .rstn(rstn), .ready(nz_ready),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(nz_rd_data), .rd_valid(nz_rd_valid),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_conflict(nz_wr_conflict)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rd(input int p, input logic [5:0] a, input logic [31:0] e, input string tag);
        rd_en[p]             = 1'b1;
        rd_addr[p*AW +: AW]  = a;
        sb.push_back('{p, e, tag});
    endtask

    task automatic wr(input int p, input logic [5:0] a, input logic [31:0] d);
        wr_en[p]             = 1'b1;
        wr_addr[p*AW +: AW]  = a;
        wr_data[p*DW +: DW]  = d;
    endtask

    // Advance one edge, sample 1ns later, retire every queued read, and
    // return request inputs to idle.
    task automatic tick();
        logic [NR-1:0] mask;
        rd_exp_t       e;
        @(posedge clk);
        #1;
        mask = '0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            mask[e.port] = 1'b1;
            check(e.tag, {32'b0, rd_data[e.port*DW +: DW]}, {32'b0, e.data});
        end
        check("rd_valid", {56'b0, rd_valid}, {56'b0, mask});
        rd_en = '0;
        wr_en = '0;
    endtask

    // Run the 64-edge init sequence with every read enabled and a
    // conflicting write pair asserted; all of it must be ignored.
    task automatic run_init(input string tag);
        for (int k = 1; k <= 64; k++) begin
            rd_en = '1;
            wr(0, 6'd5, 32'h0000AAAA);
            wr(1, 6'd5, 32'h0000BBBB);
            tick();
            check({tag, "_ready"}, {63'b0, ready}, {63'b0, (k == 64)});
            check({tag, "_conflict"}, {63'b0, wr_conflict}, 64'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn    = 1'b0;
        rd_en   = '0;
        rd_addr = '0;
        wr_en   = '0;
        wr_addr = '0;
        wr_data = '0;

        // Reset state
        tick();
        tick();
        check("rst_ready",    {63'b0, ready},       64'd0);
        check("rst_conflict", {63'b0, wr_conflict}, 64'd0);
        check("rst_data_nz",  {63'b0, |rd_data},    64'd0);

        // Initialisation
        rstn = 1'b1;
        run_init("init");

        // Initial contents: entry i holds i
        rd(0, 6'd0,  32'd0,  "init_rd0");
        rd(1, 6'd5,  32'd5,  "init_rd5");
        rd(2, 6'd63, 32'd63, "init_rd63");
        rd(3, 6'd1,  32'd1,  "init_rd1");
        rd(7, 6'd33, 32'd33, "init_rd33");
        tick();

        // Basic latency
        wr(0, 6'd7, 32'hDEADBEEF);
        tick();
        rd(3, 6'd7, 32'hDEADBEEF, "lat_rd7");
        tick();
        tick();
        check("hold_rd7", {32'b0, rd_data[3*DW +: DW]}, {32'b0, 32'hDEADBEEF});

        // Bypass, including two ports reading the same address
        wr(1, 6'd9, 32'h12345678);
        rd(0, 6'd9, 32'h12345678, "byp_p0");
        rd(4, 6'd9, 32'h12345678, "byp_p4");
        tick();
        rd(0, 6'd9, 32'h12345678, "byp_later");
        tick();
        wr(0, 6'd10, 32'h00001010);
        wr(1, 6'd11, 32'h00001111);
        rd(5, 6'd10, 32'h00001010, "byp_w0");
        rd(6, 6'd11, 32'h00001111, "byp_w1");
        tick();
        check("no_conflict", {63'b0, wr_conflict}, 64'd0);

        // Conflict: highest port wins
        wr(0, 6'd20, 32'h0000AAAA);
        wr(1, 6'd20, 32'h0000BBBB);
        rd(2, 6'd20, 32'h0000BBBB, "cfl_byp");
        tick();
        check("cfl_pulse", {63'b0, wr_conflict}, 64'd1);
        rd(2, 6'd20, 32'h0000BBBB, "cfl_store");
        tick();
        check("cfl_clear", {63'b0, wr_conflict}, 64'd0);

        // Zero register (and the same stimulus on a ZERO_REG=0 instance)
        wr(0, 6'd0, 32'hFFFFFFFF);
        wr(1, 6'd0, 32'hFFFFFFFF);
        rd(0, 6'd0, 32'd0, "zero_byp");
        tick();
        check("zero_conflict",    {63'b0, wr_conflict},    64'd0);
        check("nz_conflict",      {63'b0, nz_wr_conflict}, 64'd1);
        check("nz_byp",           {32'b0, nz_rd_data[0 +: DW]}, {32'b0, 32'hFFFFFFFF});
        rd(0, 6'd0, 32'd0, "zero_store");
        tick();
        check("nz_store",         {32'b0, nz_rd_data[0 +: DW]}, {32'b0, 32'hFFFFFFFF});

        // Read burst, then reset mid-operation
        rd(0, 6'd7,  32'hDEADBEEF, "burst0");
        rd(1, 6'd9,  32'h12345678, "burst1");
        rd(2, 6'd20, 32'h0000BBBB, "burst2");
        rd(3, 6'd0,  32'd0,        "burst3");
        rd(4, 6'd5,  32'd5,        "burst4");
        rd(5, 6'd63, 32'd63,       "burst5");
        rd(6, 6'd10, 32'h00001010, "burst6");
        rd(7, 6'd11, 32'h00001111, "burst7");
        tick();
        rstn  = 1'b0;
        rd_en = '1;
        tick();
        check("mrst_ready",   {63'b0, ready},    64'd0);
        check("mrst_data_nz", {63'b0, |rd_data}, 64'd0);
        rstn = 1'b1;
        run_init("reinit");

        // Contents restored by re-initialisation
        rd(0, 6'd7,  32'd7,  "reinit_rd7");
        rd(1, 6'd9,  32'd9,  "reinit_rd9");
        rd(2, 6'd20, 32'd20, "reinit_rd20");
        rd(3, 6'd63, 32'd63, "reinit_rd63");
        tick();
        check("nz_reinit_rd0_ready", {63'b0, nz_ready}, 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
